// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one memory port between ibus and dbus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    output logic [31:0]           i_data,
    input  logic                  d_valid,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [2:0]            d_size,
    input  logic [DATA_W/8-1:0]   d_strobe,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    output logic [DATA_W-1:0]     d_data,
    output logic                  m_valid,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [2:0]            m_size,
    output logic [DATA_W/8-1:0]   m_strobe,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ok,
    input  logic [DATA_W-1:0]     m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic       c_OWN_I = 1'b0;
    localparam logic       c_OWN_D = 1'b1;
    localparam logic [2:0] c_ISIZE = 3'b010;

    state_t r_state;
    logic   r_owner;
    logic   r_last_grant;
    logic   r_drop;

    logic        w_grant_d;
    logic        w_owner_valid;
    logic        w_drop_now;
    logic [31:0] w_iword;

    // On a tie the bus that did not win last time gets the port.
    assign w_grant_d     = d_valid & (~i_valid | (r_last_grant == c_OWN_I));
    assign w_owner_valid = (r_owner == c_OWN_D) ? d_valid : i_valid;
    assign w_drop_now    = r_drop | ~w_owner_valid;
    assign w_iword       = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= c_OWN_I;
            r_last_grant <= c_OWN_D;
            r_drop       <= 1'b0;
            m_valid      <= 1'b0;
            m_addr       <= '0;
            m_size       <= '0;
            m_strobe     <= '0;
            m_wdata      <= '0;
            i_addr_ok    <= 1'b0;
            i_data_ok    <= 1'b0;
            i_data       <= '0;
            d_addr_ok    <= 1'b0;
            d_data_ok    <= 1'b0;
            d_data       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid | d_valid) begin
                        r_state      <= S_BUSY;
                        m_valid      <= 1'b1;
                        r_drop       <= 1'b0;
                        r_owner      <= w_grant_d;
                        r_last_grant <= w_grant_d;
                        if (w_grant_d) begin
                            m_addr   <= d_addr;
                            m_size   <= d_size;
                            m_strobe <= d_strobe;
                            m_wdata  <= d_wdata;
                        end else begin
                            m_addr   <= i_addr;
                            m_size   <= c_ISIZE;
                            m_strobe <= '0;
                            m_wdata  <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_owner_valid) begin
                        r_drop <= 1'b1;
                    end
                    // An abandoned access still runs to completion; only the reply is withheld.
                    if (m_ok) begin
                        r_state <= S_DONE;
                        m_valid <= 1'b0;
                        if (!w_drop_now) begin
                            if (r_owner == c_OWN_D) begin
                                d_addr_ok <= 1'b1;
                                d_data_ok <= 1'b1;
                                d_data    <= m_rdata;
                            end else begin
                                i_addr_ok <= 1'b1;
                                i_data_ok <= 1'b1;
                                i_data    <= w_iword;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    i_addr_ok <= 1'b0;
                    i_data_ok <= 1'b0;
                    i_data    <= '0;
                    d_addr_ok <= 1'b0;
                    d_data_ok <= 1'b0;
                    d_data    <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
